mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port, synchronous-read memory between the fetch requester (instruction
//  reads) and the data-memory requester (loads/stores) of the lapido pipeline.
//  Grants one access at a time through an FSM, with data priority and a fetch anti-starvation limit.
//  Returns read data with a one-cycle valid pulse and drives per-port stall signals for the pipeline.
//  Supports discarding an in-flight fetch when a branch or jump redirects the PC.
// PARAMETERS
//  ADDR_WIDTH    8  memory word-address width
//  READ_LATENCY  1  cycles from mem_addr valid to mem_rdata valid (>=1)
//  MAX_IF_WAIT   3  consecutive data grants while if_req is pending before fetch is forced (>=1)
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           asynchronous reset, active-high
//  if_req     in   1           fetch read request; held until if_valid or if_flush
//  if_addr    in   ADDR_WIDTH  fetch address
//  if_flush   in   1           discard in-flight fetch (branch taken / jump)
//  if_rdata   out  32          fetched word
//  if_valid   out  1           if_rdata valid, one-cycle pulse
//  if_stall   out  1           if_req & ~if_valid
//  dm_req     in   1           data access request; held until dm_valid
//  dm_we      in   1           1 = write, 0 = read
//  dm_addr    in   ADDR_WIDTH  data address
//  dm_wdata   in   32          store data
//  dm_rdata   out  32          load data
//  dm_valid   out  1           access complete (read data valid / write done), one-cycle pulse
//  dm_stall   out  1           dm_req & ~dm_valid
//  mem_addr   out  ADDR_WIDTH  memory address
//  mem_we     out  1           memory write enable
//  mem_wdata  out  32          memory write data
//  mem_rdata  in   32          memory read data
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0; starvation counter 0; discard flag 0. Reset mid-access
//   aborts it immediately: mem_we drops asynchronously and no valid pulse is produced.
//  FSM states: IDLE, READ, WRITE, RESP.
//   IDLE: arbitrate on sampled requests and latch addr/wdata/we and owner at the clock edge.
//    Winner: dm if dm_req and (if_cnt < MAX_IF_WAIT or ~if_req); otherwise if if if_req.
//    dm read or fetch -> READ with wait counter = READ_LATENCY. dm write -> WRITE. No request -> stay.
//   READ: mem_addr = latched addr; decrement counter; at 1 -> RESP, capturing mem_rdata into
//    the owner's rdata register at that edge.
//   WRITE: mem_we=1, mem_addr/mem_wdata = latched values for exactly one cycle -> RESP.
//   RESP: owner's valid=1 for one cycle -> IDLE. Request lines are ignored in RESP.
//  Latency from request in IDLE: read valid at cycle READ_LATENCY+1, write at cycle 2.
//   Back-to-back accesses issue every READ_LATENCY+2 (read) / 3 (write) cycles.
//  Outside READ/WRITE: mem_addr=0, mem_we=0, mem_wdata=0. mem_we is never 1 outside WRITE.
//  if_rdata/dm_rdata hold their last captured value until the next capture for that port.
//  Starvation: if_cnt (saturating, width clog2(MAX_IF_WAIT+1)) +1 on each IDLE dm grant with
//   if_req high; cleared on a fetch grant or when if_req is low in IDLE.
//  if_flush: while owner=fetch in READ (or on the RESP edge), set discard; RESP then yields
//   if_valid=0 and leaves if_rdata unchanged. Discard clears on return to IDLE.
//   if_flush is ignored in IDLE and for dm-owned accesses.
//  if_stall/dm_stall are combinational from req and valid and are 0 during reset.
// TESTING
//  T1 READ_LATENCY=2, fetch only: if_req at c0, if_addr=0x05, mem_rdata=0xDEADBEEF ->
//     mem_addr=0x05 in c1-c2; if_valid=1 and if_rdata=0xDEADBEEF in c3; if_stall=1 in c0-c2.
//  T2 if_req and dm_req (read 0x10) both at c0 -> dm served first, dm_valid at c3; fetch granted
//     at c4 (IDLE), if_valid at c7.
//  T3 MAX_IF_WAIT=2, dm_req held continuously with if_req -> two dm accesses, then fetch granted
//     on the 3rd arbitration; if_cnt returns to 0.
//  T4 dm write addr 0x20, wdata 0x12345678 at c0 -> mem_we=1 only in c1 with these values;
//     dm_valid at c2; dm_rdata unchanged.
//  T5 fetch in READ, if_flush pulsed in c1 -> no if_valid; FSM back in IDLE at c4 (L=2);
//     if_rdata keeps its old value.
//  T6 rst asserted mid-WRITE -> mem_we=0 immediately, no dm_valid; after release, FSM is IDLE
//     and all outputs are 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals shared by the
// arbiter and its environment (pipeline requesters plus the memory macro).
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_flush;
  logic [31:0]           if_rdata;
  logic                  if_valid;
  logic                  if_stall;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [31:0]           dm_wdata;
  logic [31:0]           dm_rdata;
  logic                  dm_valid;
  logic                  dm_stall;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  // Environment side: pipeline requesters and the memory returning read data.
  modport master (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_valid, if_stall,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_valid, dm_stall,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_valid, if_stall,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_valid, dm_stall,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the lapido pipeline: fetch and data
// requesters share one synchronous-read memory. Data wins arbitration unless
// fetch has already waited MAX_IF_WAIT data grants. An in-flight fetch can be
// discarded by if_flush so a stale instruction never reaches the pipeline.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int MAX_IF_WAIT  = 3
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam int CW = $clog2(MAX_IF_WAIT + 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(READ_LATENCY);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_IF_WAIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [LW-1:0]         lat_cnt_r, lat_cnt_s;
  logic [CW-1:0]         if_cnt_r, if_cnt_s;
  logic                  owner_dm_r, owner_dm_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [31:0]           wdata_r, wdata_s;
  logic                  discard_r, discard_s;
  logic [31:0]           if_rdata_r, if_rdata_s;
  logic [31:0]           dm_rdata_r, dm_rdata_s;
  logic                  if_valid_r, if_valid_s;
  logic                  dm_valid_r, dm_valid_s;
  logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
  logic                  mem_we_r, mem_we_s;
  logic [31:0]           mem_wdata_r, mem_wdata_s;
  logic                  dm_win_s;

  // Next-state, arbitration, capture and memory-drive decode.
  always_comb begin
    state_s     = state_r;
    lat_cnt_s   = lat_cnt_r;
    if_cnt_s    = if_cnt_r;
    owner_dm_s  = owner_dm_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    discard_s   = discard_r;
    if_rdata_s  = if_rdata_r;
    dm_rdata_s  = dm_rdata_r;
    if_valid_s  = 1'b0;
    dm_valid_s  = 1'b0;
    mem_addr_s  = {ADDR_WIDTH{1'b0}};
    mem_we_s    = 1'b0;
    mem_wdata_s = 32'd0;
    dm_win_s    = bus.dm_req && ((if_cnt_r < CNT_MAX) || !bus.if_req);

    case (state_r)
      IDLE: begin
        discard_s = 1'b0;
        if (dm_win_s) begin
          owner_dm_s = 1'b1;
          addr_s     = bus.dm_addr;
          wdata_s    = bus.dm_wdata;
          if (bus.dm_we) begin
            state_s = WRITE;
          end else begin
            state_s   = READ;
            lat_cnt_s = LAT_INIT;
          end
          // Fetch was passed over once more; the guard keeps the count saturating.
          if (bus.if_req && (if_cnt_r != CNT_MAX)) begin
            if_cnt_s = if_cnt_r + CW'(1);
          end else if (bus.if_req) begin
            if_cnt_s = if_cnt_r;
          end else begin
            if_cnt_s = {CW{1'b0}};
          end
        end else if (bus.if_req) begin
          owner_dm_s = 1'b0;
          addr_s     = bus.if_addr;
          state_s    = READ;
          lat_cnt_s  = LAT_INIT;
          if_cnt_s   = {CW{1'b0}};
        end else begin
          state_s  = IDLE;
          if_cnt_s = {CW{1'b0}};
        end
      end
      READ: begin
        if (lat_cnt_r == LW'(1)) begin
          state_s = RESP;
          if (owner_dm_r) begin
            dm_rdata_s = bus.mem_rdata;
            dm_valid_s = 1'b1;
          end else if (discard_r || bus.if_flush) begin
            // Redirect arrived: drop the word and keep the old fetch data.
            discard_s = 1'b1;
          end else begin
            if_rdata_s = bus.mem_rdata;
            if_valid_s = 1'b1;
          end
        end else begin
          lat_cnt_s = lat_cnt_r - LW'(1);
          if (!owner_dm_r && bus.if_flush) begin
            discard_s = 1'b1;
          end else begin
            discard_s = discard_r;
          end
        end
      end
      WRITE: begin
        state_s    = RESP;
        dm_valid_s = 1'b1;
      end
      RESP: begin
        state_s   = IDLE;
        discard_s = 1'b0;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Memory pins follow the state being entered so they are clean flop outputs.
    if (state_s == READ) begin
      mem_addr_s = addr_s;
    end else if (state_s == WRITE) begin
      mem_addr_s  = addr_s;
      mem_we_s    = 1'b1;
      mem_wdata_s = wdata_s;
    end else begin
      mem_addr_s  = {ADDR_WIDTH{1'b0}};
      mem_we_s    = 1'b0;
      mem_wdata_s = 32'd0;
    end
  end

  // State and output registers; reset aborts any access at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      lat_cnt_r   <= {LW{1'b0}};
      if_cnt_r    <= {CW{1'b0}};
      owner_dm_r  <= 1'b0;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      wdata_r     <= 32'd0;
      discard_r   <= 1'b0;
      if_rdata_r  <= 32'd0;
      dm_rdata_r  <= 32'd0;
      if_valid_r  <= 1'b0;
      dm_valid_r  <= 1'b0;
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_we_r    <= 1'b0;
      mem_wdata_r <= 32'd0;
    end else begin
      state_r     <= state_s;
      lat_cnt_r   <= lat_cnt_s;
      if_cnt_r    <= if_cnt_s;
      owner_dm_r  <= owner_dm_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      discard_r   <= discard_s;
      if_rdata_r  <= if_rdata_s;
      dm_rdata_r  <= dm_rdata_s;
      if_valid_r  <= if_valid_s;
      dm_valid_r  <= dm_valid_s;
      mem_addr_r  <= mem_addr_s;
      mem_we_r    <= mem_we_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  assign bus.if_rdata  = if_rdata_r;
  assign bus.if_valid  = if_valid_r;
  assign bus.dm_rdata  = dm_rdata_r;
  assign bus.dm_valid  = dm_valid_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_wdata = mem_wdata_r;
  // Stalls track the live request so the pipeline freezes in the same cycle.
  assign bus.if_stall  = !rst && bus.if_req && !if_valid_r;
  assign bus.dm_stall  = !rst && bus.dm_req && !dm_valid_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level model that schedules each
// granted access by its arbitration cycle and a reference copy of memory.
module tb_mem_arbiter;
  localparam int AW   = 8;
  localparam int L    = 2;
  localparam int MAXW = 2;

  logic clk = 1'b0;
  logic rst;
  logic poke_en;
  logic [7:0]  poke_addr;
  logic [31:0] poke_data;

  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .READ_LATENCY(L), .MAX_IF_WAIT(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  logic [31:0] mem_arr [256];
  logic [31:0] ref_mem [256];

  // Synchronous-read memory with a preload path used during reset.
  always @(posedge clk) begin
    if (poke_en) mem_arr[poke_addr] <= poke_data;
    else if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem_arr[bus.mem_addr];
  end

  int vectors = 0;
  int errors  = 0;

  // Model state: one pending access, identified by its arbitration cycle.
  int          cyc, next_arb, pend_a, pend_kind, starve;  // kind 0 none, 1 read, 2 write
  bit          pend_dm, pend_discard;
  logic [7:0]  pend_addr;
  logic [31:0] pend_wdata, pend_data, e_if_rdata, e_dm_rdata;
  bit          e_if_valid, e_dm_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    cyc = 0; next_arb = 0; pend_a = 0; pend_kind = 0; starve = 0;
    pend_dm = 1'b0; pend_discard = 1'b0;
    e_if_rdata = 32'd0; e_dm_rdata = 32'd0;
    e_if_valid = 1'b0; e_dm_valid = 1'b0;
  endtask

  task automatic expect_outputs();
    int rel;
    logic [7:0]  ea;
    logic        ewe;
    logic [31:0] ewd;
    ea = 8'd0; ewe = 1'b0; ewd = 32'd0;
    e_if_valid = 1'b0; e_dm_valid = 1'b0;
    rel = cyc - pend_a;
    if (pend_kind == 1) begin
      if (rel >= 1 && rel <= L) ea = pend_addr;
      if (rel == L + 1) begin
        if (pend_dm) begin
          e_dm_valid = 1'b1; e_dm_rdata = pend_data;
        end else if (!pend_discard) begin
          e_if_valid = 1'b1; e_if_rdata = pend_data;
        end
      end
    end else if (pend_kind == 2) begin
      if (rel == 1) begin ea = pend_addr; ewe = 1'b1; ewd = pend_wdata; end
      if (rel == 2) e_dm_valid = 1'b1;
    end
    chk("if_valid",  {31'd0, bus.if_valid}, {31'd0, e_if_valid});
    chk("dm_valid",  {31'd0, bus.dm_valid}, {31'd0, e_dm_valid});
    chk("if_rdata",  bus.if_rdata, e_if_rdata);
    chk("dm_rdata",  bus.dm_rdata, e_dm_rdata);
    chk("mem_addr",  {24'd0, bus.mem_addr}, {24'd0, ea});
    chk("mem_we",    {31'd0, bus.mem_we}, {31'd0, ewe});
    chk("mem_wdata", bus.mem_wdata, ewd);
  endtask

  task automatic model_step(input bit ireq, input logic [7:0] iaddr, input bit iflush,
                            input bit dreq, input bit dwe, input logic [7:0] daddr,
                            input logic [31:0] dwdata);
    int rel;
    rel = cyc - pend_a;
    if (pend_kind == 2 && rel == 1) ref_mem[pend_addr] = pend_wdata;
    if (pend_kind == 1 && !pend_dm && rel >= 1 && rel <= L && iflush) pend_discard = 1'b1;
    if (cyc == next_arb) begin
      pend_kind = 0; pend_a = cyc; pend_discard = 1'b0;
      if (dreq && (starve < MAXW || !ireq)) begin
        starve     = ireq ? starve + 1 : 0;
        pend_dm    = 1'b1;
        pend_kind  = dwe ? 2 : 1;
        pend_addr  = daddr;
        pend_wdata = dwdata;
        pend_data  = ref_mem[daddr];
        next_arb   = cyc + (dwe ? 3 : L + 2);
      end else if (ireq) begin
        starve    = 0;
        pend_dm   = 1'b0;
        pend_kind = 1;
        pend_addr = iaddr;
        pend_data = ref_mem[iaddr];
        next_arb  = cyc + L + 2;
      end else begin
        starve   = 0;
        next_arb = cyc + 1;
      end
    end
  endtask

  // Drive one cycle of inputs, check stalls, advance the model and check outputs.
  task automatic cycle(input bit ireq, input logic [7:0] iaddr, input bit iflush,
                       input bit dreq, input bit dwe, input logic [7:0] daddr,
                       input logic [31:0] dwdata);
    bus.if_req = ireq; bus.if_addr = iaddr; bus.if_flush = iflush;
    bus.dm_req = dreq; bus.dm_we = dwe; bus.dm_addr = daddr; bus.dm_wdata = dwdata;
    #1;
    chk("if_stall", {31'd0, bus.if_stall}, {31'd0, ireq & ~e_if_valid});
    chk("dm_stall", {31'd0, bus.dm_stall}, {31'd0, dreq & ~e_dm_valid});
    model_step(ireq, iaddr, iflush, dreq, dwe, daddr, dwdata);
    @(posedge clk); #1;
    cyc++;
    expect_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
  endtask

  // Hold each enabled request until its valid; report cycles from start to valid.
  task automatic serve(input bit f, input logic [7:0] iaddr, input bit d, input bit dwe,
                       input logic [7:0] daddr, input logic [31:0] dwdata,
                       output int t_if, output int t_dm);
    int s;
    bit fa, da;
    s = cyc; fa = f; da = d; t_if = -1; t_dm = -1;
    for (int n = 0; n < 40 && (fa || da); n++) begin
      cycle(fa, iaddr, 1'b0, da, dwe, daddr, dwdata);
      if (e_if_valid && fa) begin fa = 1'b0; t_if = cyc - s; end
      if (e_dm_valid && da) begin da = 1'b0; t_dm = cyc - s; end
    end
    chk("serve_timeout", {30'd0, fa, da}, 32'd0);
  endtask

  task automatic do_reset(input bit load_mem);
    logic [31:0] v;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 8'd0; bus.if_flush = 1'b0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 8'd0; bus.dm_wdata = 32'd0;
    if (load_mem) begin
      for (int i = 0; i < 256; i++) begin
        v = (i == 5) ? 32'hDEAD_BEEF : $urandom;
        poke_en = 1'b1; poke_addr = 8'(i); poke_data = v; ref_mem[i] = v;
        @(posedge clk); #1;
      end
      poke_en = 1'b0;
    end
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    #1;
    chk("rst_if_stall", {31'd0, bus.if_stall}, 32'd0);
    chk("rst_dm_stall", {31'd0, bus.dm_stall}, 32'd0);
    chk("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_dm_valid", {31'd0, bus.dm_valid}, 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
    chk("rst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_we",   {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_init();
  endtask

  bit          fr_active, dr_active, dr_we, fl;
  logic [7:0]  fr_addr, dr_addr;
  logic [31:0] dr_wdata, saved;
  int          t_if, t_dm, ndm;

  // Directed scenarios, reset-during-write, then random traffic.
  initial begin
    rst = 1'b1;
    poke_en = 1'b0; poke_addr = 8'd0; poke_data = 32'd0;
    do_reset(1'b1);

    // Fetch alone: valid READ_LATENCY+1 cycles after the request.
    serve(1'b1, 8'h05, 1'b0, 1'b0, 8'd0, 32'd0, t_if, t_dm);
    chk("t1_if_latency", 32'(t_if), 32'd3);
    chk("t1_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
    idle(2);

    // Simultaneous requests: data first, fetch granted right after.
    serve(1'b1, 8'h07, 1'b1, 1'b0, 8'h10, 32'd0, t_if, t_dm);
    chk("t2_dm_latency", 32'(t_dm), 32'd3);
    chk("t2_if_latency", 32'(t_if), 32'd7);
    idle(2);

    // Continuous data traffic: fetch forced after MAX_IF_WAIT grants, twice.
    for (int rep = 0; rep < 2; rep++) begin
      ndm = 0;
      for (int n = 0; n < 40 && ndm >= 0; n++) begin
        cycle(1'b1, 8'h09, 1'b0, 1'b1, 1'b0, 8'(n % 16), 32'd0);
        if (e_dm_valid) ndm++;
        if (e_if_valid) break;
      end
      chk("t3_dm_before_fetch", 32'(ndm), 32'(MAXW));
      idle(2);
    end

    // Data write: one mem_we cycle, dm_valid at cycle 2, dm_rdata untouched.
    saved = bus.dm_rdata;
    serve(1'b0, 8'd0, 1'b1, 1'b1, 8'h20, 32'h1234_5678, t_if, t_dm);
    chk("t4_dm_latency", 32'(t_dm), 32'd2);
    chk("t4_dm_rdata_hold", bus.dm_rdata, saved);
    idle(2);

    // Flush during the fetch READ: no valid, old word kept, IDLE again at c4.
    saved = bus.if_rdata;
    cycle(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    cycle(1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
    idle(2);
    chk("t5_if_rdata_hold", bus.if_rdata, saved);
    serve(1'b1, 8'h04, 1'b0, 1'b0, 8'd0, 32'd0, t_if, t_dm);
    chk("t5_refetch_latency", 32'(t_if), 32'd3);
    idle(2);

    // Reset in the middle of a write cycle.
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'h21, 32'hCAFE_0001);
    chk("t6_write_active", {31'd0, bus.mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_mem_we_async", {31'd0, bus.mem_we}, 32'd0);
    chk("t6_no_dm_valid", {31'd0, bus.dm_valid}, 32'd0);
    do_reset(1'b0);
    idle(1);

    // Random traffic with redirects.
    fr_active = 1'b0; dr_active = 1'b0; dr_we = 1'b0;
    fr_addr = 8'd0; dr_addr = 8'd0; dr_wdata = 32'd0;
    for (int n = 0; n < 600; n++) begin
      if (e_if_valid) fr_active = 1'b0;
      if (e_dm_valid) dr_active = 1'b0;
      fl = 1'b0;
      if (fr_active && $urandom_range(0, 9) == 0) begin
        fl = 1'b1; fr_active = 1'b0;
      end else if (!fr_active && $urandom_range(0, 2) == 0) begin
        fr_active = 1'b1; fr_addr = 8'($urandom_range(0, 15));
      end
      if (!dr_active && $urandom_range(0, 2) != 0) begin
        dr_active = 1'b1;
        dr_we = 1'($urandom_range(0, 1));
        dr_addr = 8'($urandom_range(0, 15));
        dr_wdata = $urandom;
      end
      cycle(fr_active, fr_addr, fl, dr_active, dr_we, dr_addr, dr_wdata);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
